// File: rtl/gray_code_counter.sv
// Gray-code up/down counter with synchronous load.
// A binary count is kept internally and its Gray-code image is registered
// alongside it, so g always changes in exactly one bit per count step and
// every output comes straight from a flop.
module gray_code_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] g,
  output logic             valid,
  output logic             tc
);

  // Internal binary count; g is its registered Gray image.
  logic [WIDTH-1:0] cnt;

  // Next-state values produced by the combinational block.
  logic [WIDTH-1:0] cnt_next;
  logic             valid_next;
  logic             tc_next;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] gv);
    logic [WIDTH-1:0] b;
    b            = '0;
    b[WIDTH-1]   = gv[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ gv[i];
    end
    return b;
  endfunction

  // Binary-to-Gray: adjacent binary values differ in a single Gray bit.
  function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] bv);
    return bv ^ (bv >> 1);
  endfunction

  // Choose the next count: load beats a step, and a step flags a wrap when
  // it leaves the all-ones value going up or the zero value going down.
  always_comb begin
    cnt_next   = cnt;
    valid_next = 1'b0;
    tc_next    = 1'b0;
    if (load) begin
      cnt_next   = gray_to_bin(load_val);
      valid_next = 1'b1;
    end else if (en) begin
      valid_next = 1'b1;
      if (up) begin
        cnt_next = cnt + 1'b1;
        tc_next  = (cnt == {WIDTH{1'b1}});
      end else begin
        cnt_next = cnt - 1'b1;
        tc_next  = (cnt == '0);
      end
    end
  end

  // Register count, Gray output and strobes together; reset overrides all.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      g     <= '0;
      valid <= 1'b0;
      tc    <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      g     <= bin_to_gray(cnt_next);
      valid <= valid_next;
      tc    <= tc_next;
    end
  end

endmodule
